// File: rtl/parser_sched_pkg.sv
// Shared types for the parser feed scheduler: FSM state encoding, parser bus width,
// and a width helper for the grant index and counters.
// Contents: sched_state_e, PARSER_WORD_W, idx_w().
package parser_sched_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    XFER  = 2'd1,
    DRAIN = 2'd2,
    GAP   = 2'd3
  } sched_state_e;

  localparam int PARSER_WORD_W = 32;

  // Bits needed to hold an index into n values, never less than 1 so that
  // degenerate parameter choices still produce a legal vector.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Purpose: combinational round-robin picker; first set request after ptr, with wrap.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; the caller decides when the pick is used.
// Ports: req (request vector), ptr (last winner), any (some request set), idx (winner index).
module rr_arbiter #(
  parameter int N     = 4,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic             any,
  output logic [IDX_W-1:0] idx
);

  int               j;
  logic [IDX_W-1:0] jj;

  // Offsets 1..N from ptr; offset N is ptr itself, so the last winner has the
  // lowest priority but still wins when it is the only requester.
  always_comb begin
    any = 1'b0;
    idx = '0;
    j   = 0;
    jj  = '0;
    for (int i = 1; i <= N; i++) begin
      j = int'(ptr) + i;
      if (j >= N) j = j - N;
      jj = IDX_W'(j);
      if (!any && req[jj]) begin
        any = 1'b1;
        idx = jj;
      end
    end
  end

endmodule

// File: rtl/parser_feed_scheduler.sv
// Purpose: packet-granular round-robin feed of N_PORTS word streams onto one parser bus.
// Latency: accepted source word appears on bus_o exactly 1 cycle later.
// Backpressure: ready only to the granted port in XFER/DRAIN; non-sop heads discarded in IDLE; none in GAP.
// Ports: CLK/reset (sync, active-high); req_valid_i/req_data_i/req_sop_i/req_eop_i/req_ready_o per-port
//   word handshake; bus_o/start_of_packet_o registered parser feed; grant_o last granted port;
//   busy_o FSM not idle; underrun_o/oversize_o/framing_err_o one-cycle registered event pulses.
module parser_feed_scheduler
  import parser_sched_pkg::*;
#(
  parameter int N_PORTS    = 4,
  parameter int WORD_W     = PARSER_WORD_W,
  parameter int GAP_CYCLES = 2,
  parameter int MAX_WORDS  = 160
) (
  input  logic                         CLK,
  input  logic                         reset,
  input  logic [N_PORTS-1:0]           req_valid_i,
  input  logic [N_PORTS*WORD_W-1:0]    req_data_i,
  input  logic [N_PORTS-1:0]           req_sop_i,
  input  logic [N_PORTS-1:0]           req_eop_i,
  output logic [N_PORTS-1:0]           req_ready_o,
  output logic [WORD_W-1:0]            bus_o,
  output logic                         start_of_packet_o,
  output logic [$clog2(N_PORTS)-1:0]   grant_o,
  output logic                         busy_o,
  output logic                         underrun_o,
  output logic                         oversize_o,
  output logic                         framing_err_o
);

  localparam int IDX_W = $clog2(N_PORTS);
  localparam int WC_W  = idx_w(MAX_WORDS + 1);
  localparam int GC_W  = idx_w(GAP_CYCLES + 1);

  localparam logic [WC_W-1:0] WC_LAST = WC_W'(MAX_WORDS - 1);
  localparam logic [WC_W-1:0] WC_MAX  = WC_W'(MAX_WORDS);
  localparam logic [GC_W-1:0] GC_LAST = GC_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  sched_state_e       state_q, state_d;
  logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]   grant_d;
  logic [WC_W-1:0]    word_cnt_q, word_cnt_d;
  logic [GC_W-1:0]    gap_cnt_q, gap_cnt_d;
  logic [WORD_W-1:0]  bus_d;
  logic               sop_d, underrun_d, oversize_d, framing_d;

  logic [N_PORTS-1:0] cand;
  logic               win_any;
  logic [IDX_W-1:0]   win_idx;
  logic               g_valid, g_eop;
  logic [WORD_W-1:0]  g_data;

  assign cand    = req_valid_i & req_sop_i;
  assign g_valid = req_valid_i[grant_o];
  assign g_eop   = req_eop_i[grant_o];
  assign g_data  = req_data_i[int'(grant_o) * WORD_W +: WORD_W];
  assign busy_o  = (state_q != IDLE);

  rr_arbiter #(.N(N_PORTS), .IDX_W(IDX_W)) u_arb (
    .req (cand),
    .ptr (rr_ptr_q),
    .any (win_any),
    .idx (win_idx)
  );

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    grant_d     = grant_o;
    word_cnt_d  = word_cnt_q;
    gap_cnt_d   = gap_cnt_q;
    bus_d       = '0;
    sop_d       = 1'b0;
    underrun_d  = 1'b0;
    oversize_d  = 1'b0;
    framing_d   = 1'b0;
    req_ready_o = '0;

    case (state_q)
      IDLE: begin
        // Stray mid-packet words are drained here; sop words wait for a grant.
        req_ready_o = req_valid_i & ~req_sop_i;
        framing_d   = |(req_valid_i & ~req_sop_i);
        word_cnt_d  = '0;
        if (win_any) begin
          grant_d  = win_idx;
          rr_ptr_d = win_idx;
          state_d  = XFER;
        end
      end
      XFER: begin
        req_ready_o[grant_o] = 1'b1;
        if (g_valid) begin
          bus_d = g_data;
          sop_d = (word_cnt_q == '0);
          if (word_cnt_q != WC_MAX) word_cnt_d = word_cnt_q + WC_W'(1);
          if (g_eop) begin
            gap_cnt_d = '0;
            state_d   = (GAP_CYCLES == 0) ? IDLE : GAP;
          end else if (word_cnt_q == WC_LAST) begin
            oversize_d = 1'b1;
            state_d    = DRAIN;
          end
        end else begin
          underrun_d = 1'b1;
        end
      end
      DRAIN: begin
        req_ready_o[grant_o] = 1'b1;
        if (g_valid && g_eop) begin
          gap_cnt_d = '0;
          state_d   = (GAP_CYCLES == 0) ? IDLE : GAP;
        end
      end
      GAP: begin
        if (gap_cnt_q == GC_LAST) state_d = IDLE;
        else                      gap_cnt_d = gap_cnt_q + GC_W'(1);
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      state_q           <= IDLE;
      rr_ptr_q          <= IDX_W'(N_PORTS - 1);
      grant_o           <= '0;
      word_cnt_q        <= '0;
      gap_cnt_q         <= '0;
      bus_o             <= '0;
      start_of_packet_o <= 1'b0;
      underrun_o        <= 1'b0;
      oversize_o        <= 1'b0;
      framing_err_o     <= 1'b0;
    end else begin
      state_q           <= state_d;
      rr_ptr_q          <= rr_ptr_d;
      grant_o           <= grant_d;
      word_cnt_q        <= word_cnt_d;
      gap_cnt_q         <= gap_cnt_d;
      bus_o             <= bus_d;
      start_of_packet_o <= sop_d;
      underrun_o        <= underrun_d;
      oversize_o        <= oversize_d;
      framing_err_o     <= framing_d;
    end
  end

endmodule

// File: tb/tb_parser_feed_scheduler.sv
// Bench for parser_feed_scheduler: cycle vector table for single-port sequences,
// plus source-model sequences for arbitration, oversize drain and mid-packet reset.
module tb_parser_feed_scheduler;

  localparam int NP   = 4;
  localparam int W    = 32;
  localparam int GAPC = 2;
  localparam int MAXW = 8;

  logic            CLK = 1'b0;
  logic            reset = 1'b1;
  logic [NP-1:0]   req_valid = '0, req_sop = '0, req_eop = '0;
  logic [NP*W-1:0] req_data = '0;
  logic [NP-1:0]   req_ready;
  logic [W-1:0]    bus;
  logic            sopo, busy, underrun, oversize, framing;
  logic [1:0]      grant;

  always #5 CLK = ~CLK;

  parser_feed_scheduler #(
    .N_PORTS(NP), .WORD_W(W), .GAP_CYCLES(GAPC), .MAX_WORDS(MAXW)
  ) dut (
    .CLK               (CLK),
    .reset             (reset),
    .req_valid_i       (req_valid),
    .req_data_i        (req_data),
    .req_sop_i         (req_sop),
    .req_eop_i         (req_eop),
    .req_ready_o       (req_ready),
    .bus_o             (bus),
    .start_of_packet_o (sopo),
    .grant_o           (grant),
    .busy_o            (busy),
    .underrun_o        (underrun),
    .oversize_o        (oversize),
    .framing_err_o     (framing)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    bit          rst;
    int          port;
    bit          v, s, e;
    logic [31:0] d;
    bit          x_rdy;
    logic [31:0] x_bus;
    bit          x_sop;
    logic [1:0]  x_grant;
    bit          x_busy;
    logic [2:0]  x_fl;   // {underrun, oversize, framing}
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(bit rst, int port, bit v, bit s, bit e, logic [31:0] d,
                              bit rdy, logic [31:0] xb, bit xs, int xg, bit xbusy, logic [2:0] fl);
    vec_t t;
    t.rst = rst; t.port = port; t.v = v; t.s = s; t.e = e; t.d = d;
    t.x_rdy = rdy; t.x_bus = xb; t.x_sop = xs; t.x_grant = 2'(xg); t.x_busy = xbusy; t.x_fl = fl;
    return t;
  endfunction

  // ---------------- source model / monitor ----------------
  logic [33:0] src [NP][0:31];   // {sop, eop, data}
  int          src_len [NP];
  int          src_head [NP];
  logic [31:0] obs_dat [0:63];
  bit          obs_sop [0:63];
  logic [1:0]  obs_g   [0:63];
  int          n_obs, n_under, n_over, n_frame, over_at, stray_sop;

  task automatic clear_src();
    for (int p = 0; p < NP; p++) begin
      src_len[p]  = 0;
      src_head[p] = 0;
    end
  endtask

  task automatic clear_obs();
    for (int i = 0; i < 64; i++) begin
      obs_dat[i] = '0;
      obs_sop[i] = 1'b0;
      obs_g[i]   = '0;
    end
    n_obs = 0; n_under = 0; n_over = 0; n_frame = 0; over_at = -1; stray_sop = 0;
  endtask

  task automatic load_pkt(input int p, input int n, input logic [31:0] base);
    for (int w = 0; w < n; w++) begin
      src[p][src_len[p]] = {(w == 0), (w == n - 1), 32'(base + 32'(w))};
      src_len[p]++;
    end
  endtask

  task automatic drive_heads();
    for (int p = 0; p < NP; p++) begin
      if (src_head[p] < src_len[p]) begin
        req_valid[p]        = 1'b1;
        req_sop[p]          = src[p][src_head[p]][33];
        req_eop[p]          = src[p][src_head[p]][32];
        req_data[p*W +: W]  = src[p][src_head[p]][31:0];
      end else begin
        req_valid[p]        = 1'b0;
        req_sop[p]          = 1'b0;
        req_eop[p]          = 1'b0;
        req_data[p*W +: W]  = '0;
      end
    end
  endtask

  function automatic bit all_consumed();
    for (int p = 0; p < NP; p++)
      if (src_head[p] < src_len[p]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic monitor();
    if (bus != '0) begin
      if (n_obs < 64) begin
        obs_dat[n_obs] = bus;
        obs_sop[n_obs] = sopo;
        obs_g[n_obs]   = grant;
      end
      n_obs++;
    end else if (sopo) begin
      stray_sop++;
    end
    if (underrun) n_under++;
    if (oversize) begin
      n_over++;
      over_at = n_obs;
    end
    if (framing) n_frame++;
  endtask

  // Runs the sources until they are all consumed and the DUT is idle, or (stop_port>=0)
  // until that port's head index reaches stop_head, leaving its word driven.
  task automatic run(input int budget, input int stop_port, input int stop_head, output bit timed_out);
    int            cyc;
    logic [NP-1:0] rdy;
    cyc = 0;
    timed_out = 1'b0;
    while (1) begin
      @(negedge CLK);
      drive_heads();
      if (stop_port >= 0 && src_head[stop_port] == stop_head) break;
      if (stop_port < 0 && all_consumed() && !busy) break;
      if (cyc >= budget) begin
        timed_out = 1'b1;
        break;
      end
      #1 rdy = req_ready;
      @(posedge CLK);
      #1;
      for (int p = 0; p < NP; p++)
        if (req_valid[p] && rdy[p]) src_head[p]++;
      monitor();
      cyc++;
    end
  endtask

  task automatic do_reset();
    @(negedge CLK);
    reset = 1'b1;
    req_valid = '0; req_sop = '0; req_eop = '0; req_data = '0;
    @(posedge CLK);
    #1;
    @(negedge CLK);
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    bit          to;
    vec_t        t;
    int          order [8];
    int          idx;
    logic [31:0] base;

    // Reset, 5-word packet port0, underrun on port2, framing on port3, single-word on port1.
    vq.push_back(mk(1,0,0,0,0,32'h0,  0, 32'h0,0,0,0,3'b000));
    vq.push_back(mk(1,0,0,0,0,32'h0,  0, 32'h0,0,0,0,3'b000));
    vq.push_back(mk(0,0,1,1,0,32'hA0, 0, 32'h0,0,0,1,3'b000));
    vq.push_back(mk(0,0,1,1,0,32'hA0, 1, 32'hA0,1,0,1,3'b000));
    vq.push_back(mk(0,0,1,0,0,32'hA1, 1, 32'hA1,0,0,1,3'b000));
    vq.push_back(mk(0,0,1,0,0,32'hA2, 1, 32'hA2,0,0,1,3'b000));
    vq.push_back(mk(0,0,1,0,0,32'hA3, 1, 32'hA3,0,0,1,3'b000));
    vq.push_back(mk(0,0,1,0,1,32'hA4, 1, 32'hA4,0,0,1,3'b000));
    vq.push_back(mk(0,0,0,0,0,32'h0,  0, 32'h0,0,0,1,3'b000));
    vq.push_back(mk(0,0,0,0,0,32'h0,  0, 32'h0,0,0,0,3'b000));
    vq.push_back(mk(0,2,1,1,0,32'hC0, 0, 32'h0,0,2,1,3'b000));
    vq.push_back(mk(0,2,1,1,0,32'hC0, 1, 32'hC0,1,2,1,3'b000));
    vq.push_back(mk(0,2,1,0,0,32'hC1, 1, 32'hC1,0,2,1,3'b000));
    vq.push_back(mk(0,2,0,0,0,32'h0,  1, 32'h0,0,2,1,3'b100));
    vq.push_back(mk(0,2,0,0,0,32'h0,  1, 32'h0,0,2,1,3'b100));
    vq.push_back(mk(0,2,0,0,0,32'h0,  1, 32'h0,0,2,1,3'b100));
    vq.push_back(mk(0,2,1,1,0,32'hC2, 1, 32'hC2,0,2,1,3'b000));
    vq.push_back(mk(0,2,1,0,1,32'hC3, 1, 32'hC3,0,2,1,3'b000));
    vq.push_back(mk(0,2,0,0,0,32'h0,  0, 32'h0,0,2,1,3'b000));
    vq.push_back(mk(0,2,0,0,0,32'h0,  0, 32'h0,0,2,0,3'b000));
    vq.push_back(mk(0,3,1,0,0,32'h55, 1, 32'h0,0,2,0,3'b001));
    vq.push_back(mk(0,3,1,1,0,32'hD0, 0, 32'h0,0,3,1,3'b000));
    vq.push_back(mk(0,3,1,1,0,32'hD0, 1, 32'hD0,1,3,1,3'b000));
    vq.push_back(mk(0,3,1,0,1,32'hD1, 1, 32'hD1,0,3,1,3'b000));
    vq.push_back(mk(0,3,0,0,0,32'h0,  0, 32'h0,0,3,1,3'b000));
    vq.push_back(mk(0,3,0,0,0,32'h0,  0, 32'h0,0,3,0,3'b000));
    vq.push_back(mk(0,1,1,1,1,32'hF0, 0, 32'h0,0,1,1,3'b000));
    vq.push_back(mk(0,1,1,1,1,32'hF0, 1, 32'hF0,1,1,1,3'b000));
    vq.push_back(mk(0,1,0,0,0,32'h0,  0, 32'h0,0,1,1,3'b000));
    vq.push_back(mk(0,1,0,0,0,32'h0,  0, 32'h0,0,1,0,3'b000));

    for (int i = 0; i < vq.size(); i++) begin
      t = vq[i];
      @(negedge CLK);
      reset = t.rst;
      req_valid = '0; req_sop = '0; req_eop = '0; req_data = '0;
      req_valid[t.port]        = t.v;
      req_sop[t.port]          = t.s;
      req_eop[t.port]          = t.e;
      req_data[t.port*W +: W]  = t.d;
      #1;
      if (!t.rst) chk($sformatf("vec%0d ready", i), 32'(req_ready[t.port]), 32'(t.x_rdy));
      @(posedge CLK);
      #1;
      chk($sformatf("vec%0d bus", i),   bus, t.x_bus);
      chk($sformatf("vec%0d sop", i),   32'(sopo), 32'(t.x_sop));
      chk($sformatf("vec%0d grant", i), 32'(grant), 32'(t.x_grant));
      chk($sformatf("vec%0d busy", i),  32'(busy), 32'(t.x_busy));
      chk($sformatf("vec%0d flags", i), 32'({underrun, oversize, framing}), 32'(t.x_fl));
    end

    // All four ports hold two 3-word packets each; grants rotate 0,1,2,3,0,1,2,3.
    do_reset();
    clear_src();
    clear_obs();
    for (int p = 0; p < NP; p++)
      for (int k = 0; k < 2; k++)
        load_pkt(p, 3, 32'h1000_0000 | (32'(p) << 8) | (32'(k) << 4));
    order = '{0, 1, 2, 3, 0, 1, 2, 3};
    run(300, -1, 0, to);
    chk("rr timeout", 32'(to), 32'd0);
    chk("rr word count", 32'(n_obs), 32'd24);
    for (int i = 0; i < 8; i++) begin
      base = 32'h1000_0000 | (32'(order[i]) << 8) | (32'(i / 4) << 4);
      chk($sformatf("rr pkt%0d grant", i), 32'(obs_g[i*3]), 32'(order[i]));
      for (int w = 0; w < 3; w++) begin
        idx = i * 3 + w;
        chk($sformatf("rr pkt%0d w%0d data", i, w), obs_dat[idx], base + 32'(w));
        chk($sformatf("rr pkt%0d w%0d sop", i, w), 32'(obs_sop[idx]), 32'(w == 0));
      end
    end
    chk("rr underruns", 32'(n_under), 32'd0);
    chk("rr stray sop", 32'(stray_sop), 32'd0);

    // Port1 sends 12 words with MAX_WORDS=8: 8 forwarded, 4 drained, one oversize pulse.
    clear_src();
    clear_obs();
    load_pkt(1, 12, 32'h0000_D100);
    run(200, -1, 0, to);
    chk("ovs timeout", 32'(to), 32'd0);
    chk("ovs forwarded", 32'(n_obs), 32'd8);
    for (int w = 0; w < 8; w++)
      chk($sformatf("ovs w%0d data", w), obs_dat[w], 32'h0000_D100 + 32'(w));
    chk("ovs first sop", 32'(obs_sop[0]), 32'd1);
    chk("ovs grant", 32'(obs_g[0]), 32'd1);
    chk("ovs pulses", 32'(n_over), 32'd1);
    chk("ovs pulse with word8", 32'(over_at), 32'd8);
    chk("ovs drained all", 32'(src_head[1]), 32'd12);
    chk("ovs stray sop", 32'(stray_sop), 32'd0);

    // Reset while port0 presents word 3; afterwards port0 must beat port2 (pointer back at N-1).
    clear_src();
    clear_obs();
    load_pkt(0, 6, 32'h0000_E000);
    run(50, 0, 3, to);
    chk("rst reach word3", 32'(to), 32'd0);
    chk("rst pre-words", 32'(n_obs), 32'd3);
    reset = 1'b1;
    @(posedge CLK);
    #1;
    chk("rst bus", bus, 32'd0);
    chk("rst sop", 32'(sopo), 32'd0);
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst grant", 32'(grant), 32'd0);
    chk("rst flags", 32'({underrun, oversize, framing}), 32'd0);
    @(negedge CLK);
    reset = 1'b0;
    src_head[0] = 0;
    load_pkt(2, 2, 32'h0000_E200);
    drive_heads();
    clear_obs();
    run(100, -1, 0, to);
    chk("rst2 timeout", 32'(to), 32'd0);
    chk("rst2 word count", 32'(n_obs), 32'd8);
    chk("rst2 first grant", 32'(obs_g[0]), 32'd0);
    chk("rst2 first sop", 32'(obs_sop[0]), 32'd1);
    for (int w = 0; w < 6; w++)
      chk($sformatf("rst2 w%0d data", w), obs_dat[w], 32'h0000_E000 + 32'(w));
    chk("rst2 p2 grant", 32'(obs_g[6]), 32'd2);
    chk("rst2 p2 sop", 32'(obs_sop[6]), 32'd1);
    chk("rst2 p2 w0", obs_dat[6], 32'h0000_E200);
    chk("rst2 p2 w1", obs_dat[7], 32'h0000_E201);
    chk("rst2 framing", 32'(n_frame), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
